// File: rtl/tl_ul_arb2_pkg.sv
// rtl/tl_ul_arb2_pkg.sv - shared widths, channel payload structs and lock states for the 2:1 TL-UL arbiter
package tl_arb_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 6;
  localparam int SIZE_W = 4;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 6;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W:0]    source;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } d_chan_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/tl_ul_arb2_if.sv
// rtl/tl_ul_arb2_if.sv - bundle of both master ports and the shared slave port of the arbiter
interface tl_ul_arb2_if;
  import tl_arb_pkg::*;

  logic              m0_a_valid, m1_a_valid;
  logic              m0_a_ready, m1_a_ready;
  logic [2:0]        m0_a_opcode, m1_a_opcode;
  logic [2:0]        m0_a_param, m1_a_param;
  logic [SIZE_W-1:0] m0_a_size, m1_a_size;
  logic [SRC_W-1:0]  m0_a_source, m1_a_source;
  logic [ADDR_W-1:0] m0_a_address, m1_a_address;
  logic [MASK_W-1:0] m0_a_mask, m1_a_mask;
  logic [DATA_W-1:0] m0_a_data, m1_a_data;

  logic              s_a_valid, s_a_ready;
  logic [2:0]        s_a_opcode;
  logic [2:0]        s_a_param;
  logic [SIZE_W-1:0] s_a_size;
  logic [SRC_W:0]    s_a_source;
  logic [ADDR_W-1:0] s_a_address;
  logic [MASK_W-1:0] s_a_mask;
  logic [DATA_W-1:0] s_a_data;

  logic              s_d_valid, s_d_ready;
  logic [2:0]        s_d_opcode;
  logic [1:0]        s_d_param;
  logic [SIZE_W-1:0] s_d_size;
  logic [SRC_W:0]    s_d_source;
  logic              s_d_denied;
  logic [DATA_W-1:0] s_d_data;
  logic              s_d_corrupt;

  logic              m0_d_valid, m1_d_valid;
  logic              m0_d_ready, m1_d_ready;
  logic [2:0]        m0_d_opcode, m1_d_opcode;
  logic [1:0]        m0_d_param, m1_d_param;
  logic [SIZE_W-1:0] m0_d_size, m1_d_size;
  logic [SRC_W-1:0]  m0_d_source, m1_d_source;
  logic              m0_d_denied, m1_d_denied;
  logic [DATA_W-1:0] m0_d_data, m1_d_data;
  logic              m0_d_corrupt, m1_d_corrupt;

  // Arbiter side: takes master A / slave D, drives slave A / master D.
  modport slave (
    input  m0_a_valid, m1_a_valid, m0_a_opcode, m1_a_opcode, m0_a_param, m1_a_param,
           m0_a_size, m1_a_size, m0_a_source, m1_a_source, m0_a_address, m1_a_address,
           m0_a_mask, m1_a_mask, m0_a_data, m1_a_data,
    output m0_a_ready, m1_a_ready,
    output s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data,
    input  s_a_ready,
    input  s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied, s_d_data, s_d_corrupt,
    output s_d_ready,
    output m0_d_valid, m1_d_valid, m0_d_opcode, m1_d_opcode, m0_d_param, m1_d_param,
           m0_d_size, m1_d_size, m0_d_source, m1_d_source, m0_d_denied, m1_d_denied,
           m0_d_data, m1_d_data, m0_d_corrupt, m1_d_corrupt,
    input  m0_d_ready, m1_d_ready
  );

  modport master (
    output m0_a_valid, m1_a_valid, m0_a_opcode, m1_a_opcode, m0_a_param, m1_a_param,
           m0_a_size, m1_a_size, m0_a_source, m1_a_source, m0_a_address, m1_a_address,
           m0_a_mask, m1_a_mask, m0_a_data, m1_a_data,
    input  m0_a_ready, m1_a_ready,
    input  s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data,
    output s_a_ready,
    output s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_source, s_d_denied, s_d_data, s_d_corrupt,
    input  s_d_ready,
    input  m0_d_valid, m1_d_valid, m0_d_opcode, m1_d_opcode, m0_d_param, m1_d_param,
           m0_d_size, m1_d_size, m0_d_source, m1_d_source, m0_d_denied, m1_d_denied,
           m0_d_data, m1_d_data, m0_d_corrupt, m1_d_corrupt,
    output m0_d_ready, m1_d_ready
  );

endinterface

// File: rtl/tl_ul_arb2_credit_ctr.sv
// rtl/tl_ul_arb2_credit_ctr.sv - per-master outstanding-request counter
// A response with nothing outstanding flags underflow and leaves the count at zero.
module tl_arb_credit_ctr #(
  parameter int MAX = 8,
  parameter int W   = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty,
  output logic o_underflow
);

  logic [W-1:0] r_cnt;

  assign o_full      = (r_cnt == W'(MAX));
  assign o_empty     = (r_cnt == '0);
  assign o_underflow = i_dec && o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/tl_ul_arb2.sv
// rtl/tl_ul_arb2.sv - 2:1 TL-UL arbiter: combinational round-robin A path, source-routed D path
// A stalled beat locks its grant until it fires, so the slave never sees a payload swap.
module tl_ul_arb2
  import tl_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          quiesce,
  output logic          idle,
  output logic          err,
  tl_ul_arb2_if.slave   bus
);

  lock_state_t r_state, w_state_nxt;
  logic        r_lock_gnt, r_rr, r_err;
  logic        w_gnt, w_s_a_valid, w_a_fire;
  logic [1:0]  w_a_valid, w_elig, w_full, w_empty, w_uf, w_inc, w_dec;
  logic        w_d_sel, w_d_fire;
  a_chan_t     w_m_a [2];
  a_chan_t     w_sel_a;
  d_chan_t     w_d;

  assign w_a_valid = {bus.m1_a_valid, bus.m0_a_valid};
  assign w_elig    = w_a_valid & ~w_full & {2{!quiesce}};

  assign w_m_a[0] = '{opcode: bus.m0_a_opcode, param: bus.m0_a_param, size: bus.m0_a_size,
                      source: bus.m0_a_source, address: bus.m0_a_address,
                      mask: bus.m0_a_mask, data: bus.m0_a_data};
  assign w_m_a[1] = '{opcode: bus.m1_a_opcode, param: bus.m1_a_param, size: bus.m1_a_size,
                      source: bus.m1_a_source, address: bus.m1_a_address,
                      mask: bus.m1_a_mask, data: bus.m1_a_data};

  always_comb begin
    w_gnt       = r_rr;
    w_s_a_valid = 1'b0;
    w_state_nxt = ST_OPEN;
    case (r_state)
      ST_LOCKED: begin
        w_gnt       = r_lock_gnt;
        w_s_a_valid = w_a_valid[r_lock_gnt];
      end
      default: begin
        w_gnt       = w_elig[r_rr] ? r_rr : ~r_rr;
        w_s_a_valid = |w_elig;
      end
    endcase
    w_s_a_valid = w_s_a_valid && reset_n;
    w_a_fire    = w_s_a_valid && bus.s_a_ready;
    if (w_s_a_valid && !bus.s_a_ready) begin
      w_state_nxt = ST_LOCKED;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_OPEN;
      r_lock_gnt <= 1'b0;
      r_rr       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_gnt <= w_gnt;
      if (w_a_fire) begin
        r_rr <= ~w_gnt;
      end
      r_err <= r_err | (|w_uf);
    end
  end

  assign w_sel_a         = w_gnt ? w_m_a[1] : w_m_a[0];
  assign bus.s_a_valid   = w_s_a_valid;
  assign bus.s_a_opcode  = w_sel_a.opcode;
  assign bus.s_a_param   = w_sel_a.param;
  assign bus.s_a_size    = w_sel_a.size;
  assign bus.s_a_source  = {w_gnt, w_sel_a.source};
  assign bus.s_a_address = w_sel_a.address;
  assign bus.s_a_mask    = w_sel_a.mask;
  assign bus.s_a_data    = w_sel_a.data;
  assign bus.m0_a_ready  = w_a_fire && !w_gnt;
  assign bus.m1_a_ready  = w_a_fire && w_gnt;

  // D channel: the top source bit carries the master index added on the A side.
  assign w_d = '{opcode: bus.s_d_opcode, param: bus.s_d_param, size: bus.s_d_size,
                 source: bus.s_d_source, denied: bus.s_d_denied, data: bus.s_d_data,
                 corrupt: bus.s_d_corrupt};
  assign w_d_sel       = w_d.source[SRC_W];
  assign bus.s_d_ready = reset_n && (w_d_sel ? bus.m1_d_ready : bus.m0_d_ready);
  assign w_d_fire      = bus.s_d_valid && bus.s_d_ready;

  assign bus.m0_d_valid   = reset_n && bus.s_d_valid && !w_d_sel;
  assign bus.m1_d_valid   = reset_n && bus.s_d_valid && w_d_sel;
  assign bus.m0_d_opcode  = w_d.opcode;
  assign bus.m1_d_opcode  = w_d.opcode;
  assign bus.m0_d_param   = w_d.param;
  assign bus.m1_d_param   = w_d.param;
  assign bus.m0_d_size    = w_d.size;
  assign bus.m1_d_size    = w_d.size;
  assign bus.m0_d_source  = w_d.source[SRC_W-1:0];
  assign bus.m1_d_source  = w_d.source[SRC_W-1:0];
  assign bus.m0_d_denied  = w_d.denied;
  assign bus.m1_d_denied  = w_d.denied;
  assign bus.m0_d_data    = w_d.data;
  assign bus.m1_d_data    = w_d.data;
  assign bus.m0_d_corrupt = w_d.corrupt;
  assign bus.m1_d_corrupt = w_d.corrupt;

  assign w_inc = {w_a_fire && w_gnt, w_a_fire && !w_gnt};
  assign w_dec = {w_d_fire && w_d_sel, w_d_fire && !w_d_sel};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
    tl_arb_credit_ctr #(
      .MAX (MAX_OUTSTANDING),
      .W   (CNT_W)
    ) u_ctr (
      .i_clk       (clock),
      .i_rst_n     (reset_n),
      .i_inc       (w_inc[gi]),
      .i_dec       (w_dec[gi]),
      .o_full      (w_full[gi]),
      .o_empty     (w_empty[gi]),
      .o_underflow (w_uf[gi])
    );
  end

  assign idle = w_empty[0] && w_empty[1] && !w_s_a_valid;
  assign err  = r_err;

endmodule

// File: tb/tb_tl_ul_arb2.sv
// tb/tb_tl_ul_arb2.sv - directed self-checking bench for tl_ul_arb2 with MAX_OUTSTANDING=2
module tb_tl_ul_arb2;
  import tl_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic quiesce = 1'b0;
  logic idle, err;
  int   checks = 0;
  int   errors = 0;

  tl_ul_arb2_if bus();

  tl_ul_arb2 #(.MAX_OUTSTANDING(2)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .quiesce (quiesce),
    .idle    (idle),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    bus.m0_a_valid = 0; bus.m0_a_opcode = 3'd4; bus.m0_a_param = 3'd0; bus.m0_a_size = 4'd2;
    bus.m0_a_source = 6'h11; bus.m0_a_address = 30'h1000; bus.m0_a_mask = 4'hF; bus.m0_a_data = 32'hA0A0_0000;
    bus.m1_a_valid = 0; bus.m1_a_opcode = 3'd0; bus.m1_a_param = 3'd0; bus.m1_a_size = 4'd2;
    bus.m1_a_source = 6'h22; bus.m1_a_address = 30'h2000; bus.m1_a_mask = 4'h3; bus.m1_a_data = 32'hB1B1_1111;
    bus.s_a_ready = 0;
    bus.s_d_valid = 0; bus.s_d_opcode = 3'd1; bus.s_d_param = 2'd0; bus.s_d_size = 4'd2;
    bus.s_d_source = 7'h00; bus.s_d_denied = 0; bus.s_d_data = 32'hDEAD_BEEF; bus.s_d_corrupt = 0;
    bus.m0_d_ready = 0; bus.m1_d_ready = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    bus.m0_a_valid = 1; bus.m1_a_valid = 1; bus.s_a_ready = 1;
    bus.s_d_valid = 1; bus.s_d_source = 7'h40; bus.m0_d_ready = 1; bus.m1_d_ready = 1;
    #1;
    checks++; if (bus.s_a_valid !== 1'b0) begin errors++; $display("FAIL rst_s_a_valid got %b exp 0", bus.s_a_valid); end
    checks++; if (bus.m0_a_ready !== 1'b0 || bus.m1_a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b%b exp 00", bus.m1_a_ready, bus.m0_a_ready); end
    checks++; if (bus.s_d_ready !== 1'b0) begin errors++; $display("FAIL rst_s_d_ready got %b exp 0", bus.s_d_ready); end
    checks++; if (bus.m1_d_valid !== 1'b0) begin errors++; $display("FAIL rst_m1_d_valid got %b exp 0", bus.m1_d_valid); end
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rst_idle_err got %b/%b exp 1/0", idle, err); end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
  endtask

  task automatic test_round_robin;
    logic       e;
    logic [6:0] exp_src;
    @(negedge clk);
    bus.m0_a_valid = 1; bus.m1_a_valid = 1; bus.s_a_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k % 2) == 1;
      exp_src = e ? 7'h62 : 7'h11;
      checks++; if (bus.s_a_source !== exp_src) begin errors++; $display("FAIL rr_src%0d got %h exp %h", k, bus.s_a_source, exp_src); end
      checks++; if (bus.s_a_address !== (e ? 30'h2000 : 30'h1000)) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", k, bus.s_a_address, e ? 30'h2000 : 30'h1000); end
      checks++; if (bus.m0_a_ready !== !e || bus.m1_a_ready !== e) begin errors++; $display("FAIL rr_ready%0d got %b%b exp %b%b", k, bus.m1_a_ready, bus.m0_a_ready, e, !e); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.s_a_valid !== 1'b0) begin errors++; $display("FAIL rr_full_valid got %b exp 0", bus.s_a_valid); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL rr_full_idle got %b exp 0", idle); end
  endtask

  task automatic test_d_routing;
    @(negedge clk);
    bus.m0_a_valid = 0; bus.m1_a_valid = 0; bus.s_a_ready = 0;
    bus.s_d_valid = 1; bus.s_d_source = 7'h45; bus.m0_d_ready = 1; bus.m1_d_ready = 0;
    #1;
    checks++; if (bus.m1_d_valid !== 1'b1 || bus.m0_d_valid !== 1'b0) begin errors++; $display("FAIL d_valid got %b%b exp 10", bus.m1_d_valid, bus.m0_d_valid); end
    checks++; if (bus.m1_d_source !== 6'h05) begin errors++; $display("FAIL d_m1_source got %h exp 05", bus.m1_d_source); end
    checks++; if (bus.m1_d_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL d_m1_data got %h exp deadbeef", bus.m1_d_data); end
    checks++; if (bus.s_d_ready !== 1'b0) begin errors++; $display("FAIL d_ready_low got %b exp 0", bus.s_d_ready); end
    @(negedge clk);
    bus.m1_d_ready = 1;
    #1;
    checks++; if (bus.s_d_ready !== 1'b1) begin errors++; $display("FAIL d_ready_high got %b exp 1", bus.s_d_ready); end
    @(negedge clk);
    @(negedge clk);
    bus.s_d_source = 7'h05; bus.m1_d_ready = 0;
    #1;
    checks++; if (bus.m0_d_valid !== 1'b1 || bus.m1_d_valid !== 1'b0) begin errors++; $display("FAIL d0_valid got %b%b exp 01", bus.m1_d_valid, bus.m0_d_valid); end
    checks++; if (bus.m0_d_source !== 6'h05 || bus.s_d_ready !== 1'b1) begin errors++; $display("FAIL d0_src_ready got %h/%b exp 05/1", bus.m0_d_source, bus.s_d_ready); end
    @(negedge clk);
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL d_drain_idle_mid got %b exp 0", idle); end
    @(negedge clk);
    bus.s_d_valid = 0;
    #1;
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL d_drain_done got %b/%b exp 1/0", idle, err); end
  endtask

  task automatic test_stall_lock;
    @(negedge clk);
    bus.m0_a_valid = 1; bus.s_a_ready = 1;
    #1;
    checks++; if (bus.m0_a_ready !== 1'b1) begin errors++; $display("FAIL lk_pre_fire got %b exp 1", bus.m0_a_ready); end
    @(negedge clk);
    bus.s_a_ready = 0;
    #1;
    checks++; if (bus.s_a_valid !== 1'b1 || bus.s_a_source[6] !== 1'b0 || bus.m0_a_ready !== 1'b0) begin errors++; $display("FAIL lk_c0 got v%b g%b r%b exp v1 g0 r0", bus.s_a_valid, bus.s_a_source[6], bus.m0_a_ready); end
    @(negedge clk);
    bus.m1_a_valid = 1;
    #1;
    checks++; if (bus.s_a_source[6] !== 1'b0 || bus.s_a_address !== 30'h1000 || bus.m1_a_ready !== 1'b0) begin errors++; $display("FAIL lk_c1 got g%b a%h r1%b exp g0 a1000 r0", bus.s_a_source[6], bus.s_a_address, bus.m1_a_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.s_a_source[6] !== 1'b0) begin errors++; $display("FAIL lk_c2 got g%b exp g0", bus.s_a_source[6]); end
    @(negedge clk);
    bus.s_a_ready = 1;
    #1;
    checks++; if (bus.m0_a_ready !== 1'b1 || bus.m1_a_ready !== 1'b0) begin errors++; $display("FAIL lk_fire got %b%b exp 01", bus.m1_a_ready, bus.m0_a_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.s_a_source[6] !== 1'b1 || bus.m1_a_ready !== 1'b1 || bus.m0_a_ready !== 1'b0) begin errors++; $display("FAIL full_m1_served%0d got g%b r%b%b exp g1 r10", k, bus.s_a_source[6], bus.m1_a_ready, bus.m0_a_ready); end
    end
    @(negedge clk);
    bus.m1_a_valid = 0;
    bus.s_d_valid = 1; bus.s_d_source = 7'h05; bus.m0_d_ready = 1;
    #1;
    checks++; if (bus.m0_a_ready !== 1'b0 || bus.s_a_valid !== 1'b0) begin errors++; $display("FAIL full_m0_blocked got r%b v%b exp r0 v0", bus.m0_a_ready, bus.s_a_valid); end
    @(negedge clk);
    bus.s_d_valid = 0;
    #1;
    checks++; if (bus.m0_a_ready !== 1'b1) begin errors++; $display("FAIL full_m0_reopen got %b exp 1", bus.m0_a_ready); end
    @(negedge clk);
    bus.m0_a_valid = 0; bus.s_a_ready = 0;
    bus.s_d_valid = 1; bus.m0_d_ready = 1; bus.m1_d_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.s_d_source = (i < 2) ? 7'h05 : 7'h45;
      @(negedge clk);
    end
    bus.s_d_valid = 0;
    #1;
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL lk_drain got %b/%b exp 1/0", idle, err); end
  endtask

  task automatic test_quiesce;
    @(negedge clk);
    bus.m0_a_valid = 1; bus.s_a_ready = 0;
    #1;
    checks++; if (bus.s_a_valid !== 1'b1 || bus.s_a_source[6] !== 1'b0) begin errors++; $display("FAIL q_stall got v%b g%b exp v1 g0", bus.s_a_valid, bus.s_a_source[6]); end
    @(negedge clk);
    quiesce = 1; bus.m1_a_valid = 1;
    #1;
    checks++; if (bus.s_a_valid !== 1'b1 || bus.s_a_source[6] !== 1'b0) begin errors++; $display("FAIL q_held got v%b g%b exp v1 g0", bus.s_a_valid, bus.s_a_source[6]); end
    @(negedge clk);
    bus.s_a_ready = 1;
    #1;
    checks++; if (bus.m0_a_ready !== 1'b1) begin errors++; $display("FAIL q_fire got %b exp 1", bus.m0_a_ready); end
    @(negedge clk);
    #1;
    checks++; if (bus.s_a_valid !== 1'b0 || bus.m1_a_ready !== 1'b0 || bus.m0_a_ready !== 1'b0) begin errors++; $display("FAIL q_blocked got v%b r%b%b exp v0 r00", bus.s_a_valid, bus.m1_a_ready, bus.m0_a_ready); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL q_busy got %b exp 0", idle); end
    @(negedge clk);
    bus.m0_a_valid = 0; bus.m1_a_valid = 0;
    bus.s_d_valid = 1; bus.s_d_source = 7'h00; bus.m0_d_ready = 1;
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL q_pre_d got %b exp 0", idle); end
    @(negedge clk);
    bus.s_d_valid = 0;
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL q_idle got %b exp 1", idle); end
    quiesce = 0; bus.s_a_ready = 0;
  endtask

  task automatic test_err;
    @(negedge clk);
    bus.s_d_valid = 1; bus.s_d_source = 7'h40; bus.m1_d_ready = 1;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err); end
    @(negedge clk);
    bus.s_d_valid = 0;
    #1;
    checks++; if (err !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL err_set got %b idle %b exp 1 idle 1", err, idle); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.m0_a_valid = 1; bus.s_a_ready = 1;
    @(negedge clk);
    bus.m0_a_valid = 0; bus.s_a_ready = 0;
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", idle); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ar_async got idle %b err %b exp 1/0", idle, err); end
    @(negedge clk);
    rst_n = 1;
    bus.s_d_valid = 1; bus.s_d_source = 7'h00; bus.m0_d_ready = 1;
    @(negedge clk);
    bus.s_d_valid = 0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_cnt_cleared got err %b exp 1", err); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_d_routing();
    test_stall_lock();
    test_quiesce();
    test_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_arb2.md
TL_UL_ARB2 -- requirements
Module: tl_ul_arb2

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: maximum in-flight A requests per master (range 1..63).
REQ-002 SHALL have port clock  in  1  the only clock; all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_a_valid, m1_a_valid  in  1  master A request valid.
REQ-005 SHALL have ports m0_a_ready, m1_a_ready  out  1  master A accept.
REQ-006 SHALL have ports m{0,1}_a_{opcode,param,size,source,address,mask,data}  in  3/3/4/6/30/4/32  master A payload.
REQ-007 SHALL have port s_a_valid  out  1 and s_a_ready  in  1  shared slave A handshake.
REQ-008 SHALL have port s_a_{opcode,param,size,source,address,mask,data}  out  3/3/4/7/30/4/32  shared A payload; source[6] = master index.
REQ-009 SHALL have port s_d_valid  in  1 and s_d_ready  out  1  shared slave D handshake.
REQ-010 SHALL have port s_d_{opcode,param,size,source,denied,data,corrupt}  in  3/2/4/7/1/32/1  slave D payload.
REQ-011 SHALL have ports m{0,1}_d_valid  out  1 and m{0,1}_d_ready  in  1  per-master D handshake.
REQ-012 SHALL have ports m{0,1}_d_{opcode,param,size,source,denied,data,corrupt}  out  3/2/4/6/1/32/1  routed D payload.
REQ-013 SHALL have port quiesce  in  1  block new grants; idle  out  1  no requests in flight; err  out  1  sticky protocol error.

Function
REQ-014 A path SHALL be combinational: zero-cycle latency from granted m_a_valid to s_a_valid; payload forwarded unchanged except s_a_source = {grant, m_a_source}.
REQ-015 Master i eligible iff mi_a_valid && cnt_i < MAX_OUTSTANDING && !quiesce.
REQ-016 Arbitration SHALL be round-robin: rr pointer names preferred master; if preferred ineligible, other eligible master wins.
REQ-017 On s_a fire, rr pointer SHALL move to the master not just served.
REQ-018 Stall lock: if s_a_valid && !s_a_ready, grant SHALL be registered and held next cycle regardless of other master or quiesce until that beat fires.
REQ-019 mi_a_ready = s_a_ready && grant==i && s_a_valid; non-granted master ready SHALL be 0.
REQ-020 D routing: s_d_source[6] selects master; m_d_valid = s_d_valid for selected only; s_d_ready = selected master's d_ready; m_d_source = s_d_source[5:0].
REQ-021 cnt_i SHALL increment on A fire for i, decrement on D fire for i, unchanged when both same cycle.
REQ-022 D fire for master with cnt_i==0 SHALL set err (sticky), cnt stays 0.
REQ-023 idle = (cnt_0==0 && cnt_1==0 && !s_a_valid), combinational.
REQ-024 quiesce asserted mid-lock SHALL not drop held beat; effective from next grant decision.

Reset
REQ-025 While reset_n low: s_a_valid, m*_a_ready, s_d_ready, m*_d_valid forced 0; cnt=0; rr=0 (master 0 preferred); lock cleared; err=0; idle=1.
REQ-026 Reset asserted mid-transfer SHALL discard lock and counters immediately (asynchronously); no recovery of in-flight state.

Structure
REQ-027 Shared package tl_arb_pkg SHALL hold width constants (addr 30, data 32, source 6, size 4) and A/D payload struct typedefs.
REQ-028 Per-master outstanding counter SHALL be sub-module tl_arb_credit_ctr (inc, dec, full, empty, underflow), instantiated twice.

Verification
REQ-029 Both masters valid continuously, s_a_ready=1 -> grants alternate 0,1,0,1; s_a_source[6] alternates.
REQ-030 m0 valid, s_a_ready=0 for 3 cycles, m1 raised cycle 1 -> grant stays 0 until fire, then m1 granted.
REQ-031 MAX_OUTSTANDING=2, m0 issues 2 requests, no D -> m0_a_ready=0, m1 still served; one D for source 0x05 -> m0 eligible again.
REQ-032 s_d source 0x45 -> m1_d_valid=1, m1_d_source=0x05, m0_d_valid=0; s_d_ready follows m1_d_ready.
REQ-033 D fire for master 1 with cnt_1==0 -> err=1 next cycle, held until reset_n low.
REQ-034 quiesce=1 with 1 pending beat stalled -> beat completes, no further grants, idle=1 after last D.
